fir_parallel_prog: RTL and testbench
====================================

Name: fir_parallel_prog

Overview:
- Parametrised L-way block-parallel FIR filter with runtime-programmable coefficients. It is the next generation of the team's fixed 3-parallel, 102-tap low-pass filter.
- Each cycle it accepts one block of L consecutive samples and produces L filtered outputs, so throughput is L samples per clock.
- The filter core uses a registered product stage followed by a fully pipelined adder tree.
- Coefficients live in a double-buffered (shadow/active) bank, so a new coefficient set loads without corrupting samples already in flight.
- The output stage applies configurable rounding and saturation.

Parameters:
- L, 3, parallelism: samples per block (1..8).
- NUM_TAPS, 102, filter length N (2..256).
- DATA_W, 32, signed input sample width.
- COEF_W, 32, signed coefficient width.
- OUT_W, 64, signed output width after shift and saturation.
- OUT_SHIFT, 0, right-shift applied to the full-precision sum before saturation.
- ACC_W (derived, not overridable) = DATA_W + COEF_W + clog2(NUM_TAPS).
- LAT (derived) = 2 + clog2(NUM_TAPS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data carries a valid block this cycle.
- in_data  in  L*DATA_W  lane j = sample x[kL+j]; lane 0 is the oldest in the block.
- flush  in  1  synchronous clear of the sample history.
- coef_we  in  1  write coef_wdata into shadow[coef_addr].
- coef_addr  in  clog2(NUM_TAPS)  tap index.
- coef_wdata  in  COEF_W  signed coefficient.
- coef_commit  in  1  copy the whole shadow bank into the active bank.
- out_valid  out  1  out_data is valid.
- out_data  out  L*OUT_W  lane j = y[kL+j].
- out_sat  out  L  per-lane flag: saturation occurred in this output.

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - Clears the history, both coefficient banks, all pipeline registers, out_valid, out_data and out_sat to 0.
  - Reset asserted mid-stream discards all in-flight blocks. No out_valid pulse follows for them.
- Function: y[n] = sum over t = 0..N-1 of h[t]*x[n-t], with x[m] = 0 for samples before reset or flush.
  - Arithmetic is full precision and signed, in ACC_W bits. No intermediate wrap is permitted.
- History: a shift register of N-1+L samples.
  - It advances by L only on edges where in_valid=1; gaps in in_valid freeze it.
  - flush=1 zeroes the history at that edge. If in_valid=1 on the same edge, the block is accepted into the cleared history (flush applies first).
- Pipeline:
  - Stage 0: history capture at the acceptance edge E.
  - Stage 1: L*N products registered at E+1.
  - Stages 2..LAT-1: one registered adder-tree level each (pairwise; an odd leftover is passed through).
  - Output stage: round/shift/saturate registered.
  - out_valid=1 exactly for the cycle after edge E+LAT; one output pulse per accepted block, in order.
  - The valid shift register advances every cycle, including during input gaps.
  - No backpressure: the downstream always accepts.
- Output stage:
  - If OUT_SHIFT>0: add 2^(OUT_SHIFT-1), then arithmetic shift right (round half up).
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat[j]=1 when the clamp engages.
  - out_data and out_sat hold their last value while out_valid=0.
- Coefficients:
  - coef_we writes the shadow bank only.
  - coef_commit copies shadow to active at its edge C.
  - Blocks accepted at edges >= C use the new set; blocks accepted before C complete with the old set.
  - coef_we and coef_commit on the same edge: the commit copies the pre-write shadow value; the write lands in the shadow bank only.
  - coef_addr >= NUM_TAPS: the write is ignored.

Test Plan:
- L=3, N=8, h=1..8, committed; impulse x[0]=1, all other samples 0, continuous valid -> y[0..7]=1..8, then 0. First out_valid occurs LAT=5 cycles after acceptance.
- Same h; step x=1 for all samples -> y[n]=(n+1)(n+2)/2 for n<8, then a constant 36. in_valid toggled 1/0 gives the identical sequence with gaps.
- DATA_W=COEF_W=16, OUT_W=16, h[0]=32767, other taps 0; x=32767 -> out_data=32767 with out_sat=1; x=-32768 with h[0]=-32768 -> clamped to 32767 with out_sat=1.
- OUT_SHIFT=2, h[0]=1, other taps 0; x=6 -> 2 (6+2=8, >>2); x=5 -> 1; x=-6 -> -1.
- Load set A, commit, stream; write set B into shadow mid-stream -> outputs unchanged. Commit at edge C -> blocks accepted before C follow A, blocks at or after C follow B, with no mixed block.
- Assert rst for 1 cycle with LAT blocks in flight -> out_valid stays 0 for the next LAT cycles; both banks read 0, so post-reset outputs are 0 until new coefficients are committed.

Source files
------------

// File: rtl/fir_parallel_prog_if.sv
// Sample/coefficient/output bundle for fir_parallel_prog.
// The master drives samples and coefficients; the slave (filter) drives results.
interface fir_parallel_prog_if #(
  parameter int L        = 3,
  parameter int NUM_TAPS = 102,
  parameter int DATA_W   = 32,
  parameter int COEF_W   = 32,
  parameter int OUT_W    = 64
);
  localparam int AW = $clog2(NUM_TAPS);

  logic                  in_valid;
  logic [L*DATA_W-1:0]   in_data;
  logic                  flush;
  logic                  coef_we;
  logic [AW-1:0]         coef_addr;
  logic [COEF_W-1:0]     coef_wdata;
  logic                  coef_commit;
  logic                  out_valid;
  logic [L*OUT_W-1:0]    out_data;
  logic [L-1:0]          out_sat;

  modport master (
    output in_valid, in_data, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    input  out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, flush, coef_we, coef_addr, coef_wdata, coef_commit,
    output out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_parallel_prog.sv
// L-way block-parallel FIR with shadow/active coefficient banks, registered
// products, a pipelined pairwise adder tree and a round/saturate output stage.
module fir_parallel_prog #(
  parameter int L         = 3,
  parameter int NUM_TAPS  = 102,
  parameter int DATA_W    = 32,
  parameter int COEF_W    = 32,
  parameter int OUT_W     = 64,
  parameter int OUT_SHIFT = 0
) (
  input logic                clk,
  input logic                rst,
  fir_parallel_prog_if.slave bus
);

  localparam int AW     = $clog2(NUM_TAPS);
  localparam int LEVELS = $clog2(NUM_TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + LEVELS;
  localparam int LAT    = 2 + LEVELS;
  localparam int HIST   = NUM_TAPS + L - 1;
  localparam int EW     = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;

  localparam logic [AW:0]          TAPS_LIM = (AW + 1)'(NUM_TAPS);
  localparam logic signed [EW-1:0] OMAX     = EW'({(OUT_W - 1){1'b1}});
  localparam logic signed [EW-1:0] OMIN     = ~OMAX;
  localparam logic signed [EW-1:0] RND      = EW'((EW'(1) << OUT_SHIFT) >> 1);

  typedef logic signed [DATA_W-1:0] samp_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // Node count of tree level lv (level 0 = products) and its flat offset.
  function automatic int unsigned lvl_cnt(input int unsigned lv);
    return (NUM_TAPS + (1 << lv) - 1) >> lv;
  endfunction

  function automatic int unsigned lvl_off(input int unsigned lv);
    int unsigned s;
    s = 0;
    for (int unsigned i = 0; i < lv; i++) s += lvl_cnt(i);
    return s;
  endfunction

  localparam int unsigned NODES = lvl_off(LEVELS + 1);

  function automatic acc_t mul(input samp_t a, input coef_t b);
    acc_t ae, be;
    ae = ACC_W'(a);
    be = ACC_W'(b);
    return ae * be;
  endfunction

  samp_t              hist_q [HIST];
  samp_t              hist_d [HIST];
  coef_t              shadow_q [NUM_TAPS];
  coef_t              active_q [NUM_TAPS];
  acc_t               tree_q [L][NODES];
  logic [LAT-1:0]     vld_q;
  logic               out_valid_q;
  logic [L*OUT_W-1:0] out_data_q, out_data_d;
  logic [L-1:0]       out_sat_q, out_sat_d;
  logic signed [EW-1:0] rnd_w [L];

  // Index 0 holds the newest sample; lane L-1 of a block is the newest.
  always_comb begin
    for (int unsigned k = 0; k < HIST; k++) hist_d[k] = bus.flush ? '0 : hist_q[k];
    if (bus.in_valid) begin
      for (int unsigned k = L; k < HIST; k++) hist_d[k] = bus.flush ? '0 : hist_q[k - L];
      for (int unsigned j = 0; j < L; j++) hist_d[L - 1 - j] = bus.in_data[j*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= '{default: '0};
    else     hist_q <= hist_d;
  end

  // Products read active_q one edge after acceptance, so a commit at edge C
  // is seen exactly by blocks accepted at or after C.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      if (bus.coef_commit) active_q <= shadow_q;
      if (bus.coef_we && ({1'b0, bus.coef_addr} < TAPS_LIM)) shadow_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_q <= '{default: '{default: '0}};
      vld_q  <= '0;
    end else begin
      vld_q <= {vld_q[LAT-2:0], bus.in_valid};
      for (int unsigned j = 0; j < L; j++) begin
        for (int unsigned t = 0; t < NUM_TAPS; t++)
          tree_q[j][t] <= mul(hist_q[L - 1 - j + t], active_q[t]);
        // Pairwise reduction; an odd leftover node is forwarded unchanged.
        for (int unsigned lv = 1; lv <= LEVELS; lv++) begin
          for (int unsigned o = 0; o < lvl_cnt(lv); o++) begin
            if (2*o + 1 < lvl_cnt(lv - 1))
              tree_q[j][lvl_off(lv) + o] <= tree_q[j][lvl_off(lv - 1) + 2*o]
                                          + tree_q[j][lvl_off(lv - 1) + 2*o + 1];
            else
              tree_q[j][lvl_off(lv) + o] <= tree_q[j][lvl_off(lv - 1) + 2*o];
          end
        end
      end
    end
  end

  always_comb begin
    out_data_d = '0;
    out_sat_d  = '0;
    for (int unsigned j = 0; j < L; j++) begin
      rnd_w[j] = (EW'(tree_q[j][NODES - 1]) + RND) >>> OUT_SHIFT;
      if (rnd_w[j] > OMAX) begin
        out_data_d[j*OUT_W +: OUT_W] = OMAX[OUT_W-1:0];
        out_sat_d[j]                 = 1'b1;
      end else if (rnd_w[j] < OMIN) begin
        out_data_d[j*OUT_W +: OUT_W] = OMIN[OUT_W-1:0];
        out_sat_d[j]                 = 1'b1;
      end else begin
        out_data_d[j*OUT_W +: OUT_W] = rnd_w[j][OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      out_valid_q <= vld_q[LAT-1];
      if (vld_q[LAT-1]) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_parallel_prog.sv
// Bench for fir_parallel_prog: three configurations (wide, 16-bit saturating,
// OUT_SHIFT=2) checked against a direct-form reference through a scoreboard.
module tb_fir_parallel_prog;

  localparam int LAT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  fir_parallel_prog_if #(.L(3), .NUM_TAPS(8), .DATA_W(32), .COEF_W(32), .OUT_W(64)) if_a ();
  fir_parallel_prog_if #(.L(3), .NUM_TAPS(8), .DATA_W(16), .COEF_W(16), .OUT_W(16)) if_b ();
  fir_parallel_prog_if #(.L(3), .NUM_TAPS(8), .DATA_W(32), .COEF_W(32), .OUT_W(64)) if_c ();

  fir_parallel_prog #(.L(3), .NUM_TAPS(8), .DATA_W(32), .COEF_W(32), .OUT_W(64), .OUT_SHIFT(0))
    u_a (.clk(clk), .rst(rst), .bus(if_a));
  fir_parallel_prog #(.L(3), .NUM_TAPS(8), .DATA_W(16), .COEF_W(16), .OUT_W(16), .OUT_SHIFT(0))
    u_b (.clk(clk), .rst(rst), .bus(if_b));
  fir_parallel_prog #(.L(3), .NUM_TAPS(8), .DATA_W(32), .COEF_W(32), .OUT_W(64), .OUT_SHIFT(2))
    u_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct {
    logic [191:0] data;
    logic [2:0]   sat;
    int           due;
  } exp_t;

  exp_t   qa[$], qb[$], qc[$];
  longint hm [3][10];
  longint ca [3][8];
  longint cs [3][8];
  int     ow_of [3] = '{64, 16, 64};
  int     sh_of [3] = '{0, 0, 2};

  function automatic longint r32();
    int v;
    v = $urandom;
    return longint'(v);
  endfunction

  task automatic push_exp(input int id);
    exp_t e;
    logic signed [127:0] acc, a, b, r, mx, mn, v;
    e.data = '0;
    e.sat  = '0;
    e.due  = cyc + 1 + LAT;
    for (int j = 0; j < 3; j++) begin
      acc = '0;
      for (int t = 0; t < 8; t++) begin
        a = ca[id][t];
        b = hm[id][2 - j + t];
        acc += a * b;
      end
      r  = acc + ((sh_of[id] > 0) ? (128'sd1 <<< (sh_of[id] - 1)) : 128'sd0);
      r  = r >>> sh_of[id];
      mx = (128'sd1 <<< (ow_of[id] - 1)) - 128'sd1;
      mn = -mx - 128'sd1;
      v  = r;
      if (r > mx) begin v = mx; e.sat[j] = 1'b1; end
      else if (r < mn) begin v = mn; e.sat[j] = 1'b1; end
      if (ow_of[id] == 64) e.data[j*64 +: 64] = v[63:0];
      else                 e.data[j*16 +: 16] = v[15:0];
    end
    case (id)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic idle_all();
    if_a.in_valid = 0; if_a.flush = 0; if_a.in_data = '0; if_a.coef_we = 0;
    if_a.coef_addr = '0; if_a.coef_wdata = '0; if_a.coef_commit = 0;
    if_b.in_valid = 0; if_b.flush = 0; if_b.in_data = '0; if_b.coef_we = 0;
    if_b.coef_addr = '0; if_b.coef_wdata = '0; if_b.coef_commit = 0;
    if_c.in_valid = 0; if_c.flush = 0; if_c.in_data = '0; if_c.coef_we = 0;
    if_c.coef_addr = '0; if_c.coef_wdata = '0; if_c.coef_commit = 0;
  endtask

  // One clock: drive inputs of instance id, update the reference, push the expectation.
  task automatic step(input int id, input bit v, input bit fl, input longint x0, input longint x1,
                      input longint x2, input bit we, input int addr, input longint wd, input bit cm);
    case (id)
      0: begin
        if_a.in_valid = v; if_a.flush = fl; if_a.in_data = {x2[31:0], x1[31:0], x0[31:0]};
        if_a.coef_we = we; if_a.coef_addr = 3'(addr); if_a.coef_wdata = wd[31:0]; if_a.coef_commit = cm;
      end
      1: begin
        if_b.in_valid = v; if_b.flush = fl; if_b.in_data = {x2[15:0], x1[15:0], x0[15:0]};
        if_b.coef_we = we; if_b.coef_addr = 3'(addr); if_b.coef_wdata = wd[15:0]; if_b.coef_commit = cm;
      end
      default: begin
        if_c.in_valid = v; if_c.flush = fl; if_c.in_data = {x2[31:0], x1[31:0], x0[31:0]};
        if_c.coef_we = we; if_c.coef_addr = 3'(addr); if_c.coef_wdata = wd[31:0]; if_c.coef_commit = cm;
      end
    endcase
    if (cm) for (int t = 0; t < 8; t++) ca[id][t] = cs[id][t];
    if (we && addr < 8) cs[id][addr] = wd;
    if (fl) for (int k = 0; k < 10; k++) hm[id][k] = 0;
    if (v) begin
      for (int k = 9; k >= 3; k--) hm[id][k] = hm[id][k - 3];
      hm[id][0] = x2;
      hm[id][1] = x1;
      hm[id][2] = x0;
      push_exp(id);
    end
    @(posedge clk);
    #1;
    idle_all();
  endtask

  task automatic blk(input int id, input longint x0, input longint x1, input longint x2);
    step(id, 1, 0, x0, x1, x2, 0, 0, 0, 0);
  endtask

  task automatic gap(input int id);
    step(id, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wcoef(input int id, input int addr, input longint val);
    step(id, 0, 0, 0, 0, 0, 1, addr, val, 0);
  endtask

  task automatic commit(input int id);
    step(id, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic settle();
    repeat (LAT + 2) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every out_valid pops the oldest expectation of that instance.
  always @(negedge clk) begin : mon
    bit           valid, have;
    logic [191:0] got;
    logic [2:0]   gs;
    exp_t         e;
    for (int id = 0; id < 3; id++) begin
      have = 0;
      case (id)
        0: begin valid = if_a.out_valid; got = 192'(if_a.out_data); gs = if_a.out_sat; end
        1: begin valid = if_b.out_valid; got = 192'(if_b.out_data); gs = if_b.out_sat; end
        default: begin valid = if_c.out_valid; got = 192'(if_c.out_data); gs = if_c.out_sat; end
      endcase
      if (valid === 1'b1) begin
        case (id)
          0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1; end
          1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1; end
          default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1; end
        endcase
        n_cmp++;
        if (!have) begin
          n_bad++;
          $display("FAIL sb_unexpected[%0d]: out_valid=1 at cycle %0d, required no output", id, cyc);
        end else if (got !== e.data || gs !== e.sat || cyc != e.due) begin
          n_bad++;
          $display("FAIL sb_out[%0d]: data=%h sat=%b cycle=%0d, required data=%h sat=%b cycle=%0d",
                   id, got, gs, cyc, e.data, e.sat, e.due);
        end
      end
    end
  end

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (if_a.out_valid !== 1'b0 || if_a.out_data !== '0 || if_a.out_sat !== '0) begin
      n_bad++;
      $display("FAIL reset_a: valid=%b data=%h sat=%b, required all 0", if_a.out_valid, if_a.out_data, if_a.out_sat);
    end
    n_cmp++;
    if (if_b.out_valid !== 1'b0 || if_b.out_data !== '0 || if_b.out_sat !== '0) begin
      n_bad++;
      $display("FAIL reset_b: valid=%b data=%h sat=%b, required all 0", if_b.out_valid, if_b.out_data, if_b.out_sat);
    end
    n_cmp++;
    if (if_c.out_valid !== 1'b0 || if_c.out_data !== '0 || if_c.out_sat !== '0) begin
      n_bad++;
      $display("FAIL reset_c: valid=%b data=%h sat=%b, required all 0", if_c.out_valid, if_c.out_data, if_c.out_sat);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_impulse();
    for (int t = 0; t < 8; t++) wcoef(0, t, t + 1);
    commit(0);
    blk(0, 1, 0, 0);
    repeat (4) blk(0, 0, 0, 0);
    settle();
  endtask

  task automatic test_step();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) blk(0, 1, 1, 1);
    settle();
    step(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
    repeat (4) begin
      gap(0);
      blk(0, 1, 1, 1);
    end
    settle();
  endtask

  task automatic test_saturation();
    wcoef(1, 0, 32767);
    commit(1);
    blk(1, 32767, 32767, 1);
    wcoef(1, 0, -32768);
    commit(1);
    step(1, 1, 1, -32768, 32767, 1, 0, 0, 0, 0);
    blk(1, 0, -1, 0);
    settle();
  endtask

  task automatic test_rounding();
    wcoef(2, 0, 1);
    commit(2);
    blk(2, 6, 5, -6);
    blk(2, 7, -2, -7);
    blk(2, -5, 3, 2);
    settle();
  endtask

  task automatic test_coef_swap();
    longint set_a [8] = '{3, -1, 4, 1, -5, 9, 2, -6};
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int t = 0; t < 8; t++) wcoef(0, t, set_a[t]);
    commit(0);
    repeat (4) blk(0, r32(), r32(), r32());
    for (int t = 0; t < 8; t++) step(0, 1, 0, r32(), r32(), r32(), 1, t, r32(), 0);
    step(0, 1, 0, r32(), r32(), r32(), 0, 0, 0, 1);
    repeat (3) blk(0, r32(), r32(), r32());
    step(0, 1, 0, r32(), r32(), r32(), 1, 0, 100, 1);
    repeat (2) blk(0, r32(), r32(), r32());
    commit(0);
    repeat (2) blk(0, r32(), r32(), r32());
    settle();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 8; t++) wcoef(0, t, longint'($urandom_range(0, 2000)) - 1000);
    commit(0);
    repeat (40)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           r32(), r32(), r32(), 0, 0, 0, 0);
    settle();
  endtask

  task automatic test_reset_midstream();
    repeat (LAT) blk(0, r32(), r32(), r32());
    rst = 1'b1;
    for (int id = 0; id < 3; id++) begin
      for (int k = 0; k < 10; k++) hm[id][k] = 0;
      for (int t = 0; t < 8; t++) begin ca[id][t] = 0; cs[id][t] = 0; end
    end
    qa.delete(); qb.delete(); qc.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      n_cmp++;
      if (if_a.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_flush_valid: out_valid=%b at cycle %0d, required 0", if_a.out_valid, cyc);
      end
    end
    @(posedge clk);
    #1;
    blk(0, 5, 5, 5);
    blk(0, -7, 9, 11);
    settle();
  endtask

  task automatic test_drain_complete();
    n_cmp++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending outputs a=%0d b=%0d c=%0d, required 0", qa.size(), qb.size(), qc.size());
    end
  endtask

  initial begin
    for (int id = 0; id < 3; id++) begin
      for (int k = 0; k < 10; k++) hm[id][k] = 0;
      for (int t = 0; t < 8; t++) begin ca[id][t] = 0; cs[id][t] = 0; end
    end
    test_reset();
    test_impulse();
    test_step();
    test_saturation();
    test_rounding();
    test_coef_swap();
    test_back_to_back();
    test_reset_midstream();
    test_drain_complete();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
